// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the fetch/decode entry record and the NOP encoding
// handed to decode whenever the fetch queue has nothing valid to offer.
package pipeline_pkg;

  // Width of each instruction, PC and PC+4 field.
  localparam int FQ_DATA_WIDTH = 32;

  // Canonical NOP (addi x0, x0, 0).
  localparam logic [FQ_DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  // One fetched instruction together with its PC and PC+4.
  typedef struct packed {
    logic [FQ_DATA_WIDTH-1:0] instr;
    logic [FQ_DATA_WIDTH-1:0] pc;
    logic [FQ_DATA_WIDTH-1:0] pc_plus4;
  } fetch_entry_t;

  // Occupancy helper: true when a queue of the given depth has no free slot.
  function automatic logic occ_full(input logic [31:0] count, input logic [31:0] depth);
    return (count >= depth);
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry storage for the fetch queue: DEPTH registered entries, one write
// port and one asynchronous read port. Data words are not reset; validity is
// tracked entirely by the occupancy count in the owning queue.
module fq_storage
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  fetch_entry_t  wdata,
  input  logic [PW-1:0] raddr,
  output fetch_entry_t  rdata
);

  fetch_entry_t mem [DEPTH];

  // Write the incoming entry into the addressed slot when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode. Buffers up to DEPTH
// {instr, pc, pc+4} entries so decode stalls do not freeze the PC, throttles
// fetch through PCen_o, and drops everything on a control-flow redirect.
// The head entry drives the decode-stage inputs directly from storage.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = FQ_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n_i,
  input  logic [DATA_WIDTH-1:0]      InstrF_i,
  input  logic [DATA_WIDTH-1:0]      PCF_i,
  input  logic [DATA_WIDTH-1:0]      PCPlus4F_i,
  input  logic                       FetchValid_i,
  output logic                       PCen_o,
  input  logic                       StallD_i,
  input  logic                       FlushD_i,
  output logic [DATA_WIDTH-1:0]      InstrD_o,
  output logic [DATA_WIDTH-1:0]      PCD_o,
  output logic [DATA_WIDTH-1:0]      PCPlus4D_o,
  output logic                       ValidD_o,
  output logic [$clog2(DEPTH):0]     Count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          not_full;
  logic          head_valid;
  logic          pop;
  logic          push;
  logic          store_we;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head_entry;

  // Occupancy states (empty / partial / full) are implied by count alone.
  assign not_full   = ~occ_full(32'(count), 32'(DEPTH_C));
  assign head_valid = (count != {CW{1'b0}});

  // A full queue still accepts a new entry when the head leaves in the same cycle.
  assign pop      = head_valid & ~StallD_i;
  assign push     = FetchValid_i & (not_full | pop);
  assign PCen_o   = not_full | pop;

  // A redirect discards the entry fetched in the same cycle as well.
  assign store_we = push & ~FlushD_i;

  assign wr_entry = '{instr: InstrF_i, pc: PCF_i, pc_plus4: PCPlus4F_i};

  fq_storage #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_storage (
    .clk   (clk),
    .we    (store_we),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head_entry)
  );

  // Pointer and occupancy update; flush outranks any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (FlushD_i) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Present the head entry to decode, or a NOP with zeroed PCs when empty.
  always_comb begin
    InstrD_o   = NOP_INSTR;
    PCD_o      = {DATA_WIDTH{1'b0}};
    PCPlus4D_o = {DATA_WIDTH{1'b0}};
    if (head_valid) begin
      InstrD_o   = head_entry.instr;
      PCD_o      = head_entry.pc;
      PCPlus4D_o = head_entry.pc_plus4;
    end else begin
      InstrD_o   = NOP_INSTR;
      PCD_o      = {DATA_WIDTH{1'b0}};
      PCPlus4D_o = {DATA_WIDTH{1'b0}};
    end
  end

  assign ValidD_o = head_valid;
  assign Count_o  = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_fetch_queue;
  import pipeline_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_f = 32'h0;
  logic [31:0] pc_f = 32'h0;
  logic [31:0] pc4_f = 32'h0;
  logic        fv = 1'b0;
  logic        pcen;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        valid_d;
  logic [2:0]  count_d;

  int total = 0;
  int bad   = 0;

  fetch_entry_t model_q[$];

  fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n_i      (rst_n),
    .InstrF_i     (instr_f),
    .PCF_i        (pc_f),
    .PCPlus4F_i   (pc4_f),
    .FetchValid_i (fv),
    .PCen_o       (pcen),
    .StallD_i     (stall),
    .FlushD_i     (flush),
    .InstrD_o     (instr_d),
    .PCD_o        (pc_d),
    .PCPlus4D_o   (pc4_d),
    .ValidD_o     (valid_d),
    .Count_o      (count_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of entries; head leaves unless stalled, fetch
  // enters if there is room (or room is being made), redirect empties it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      bit m_pop;
      bit m_push;
      m_pop  = (model_q.size() > 0) && !stall;
      m_push = fv && ((model_q.size() < DEPTH) || m_pop);
      if (flush) begin
        model_q.delete();
      end else begin
        if (m_pop) void'(model_q.pop_front());
        if (m_push) model_q.push_back('{instr: instr_f, pc: pc_f, pc_plus4: pc4_f});
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int sz;
    sz = model_q.size();
    chk("count", 32'(count_d), 32'(sz));
    chk("valid", 32'(valid_d), 32'(sz > 0));
    chk("pcen", 32'(pcen), 32'((sz < DEPTH) || ((sz > 0) && !stall)));
    if (sz > 0) begin
      chk("instr", instr_d, model_q[0].instr);
      chk("pc", pc_d, model_q[0].pc);
      chk("pc4", pc4_d, model_q[0].pc_plus4);
    end else begin
      chk("instr_empty", instr_d, 32'h0000_0013);
      chk("pc_empty", pc_d, 32'h0);
      chk("pc4_empty", pc4_d, 32'h0);
    end
  end

  task automatic set_in(input logic v, input logic [31:0] pc, input logic st, input logic fl);
    fv      = v;
    pc_f    = pc;
    pc4_f   = pc + 32'd4;
    instr_f = pc ^ 32'hC0DE_0033;
    stall   = st;
    flush   = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_count", 32'(count_d), 32'd0);
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_instr", instr_d, 32'h0000_0013);
    chk("rst_pcen", 32'(pcen), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming with no stall: each entry visible one cycle after push
    set_in(1'b1, 32'h0, 1'b0, 1'b0); tick();
    chk("str_pc0", pc_d, 32'h0); chk("str_cnt0", 32'(count_d), 32'd1);
    set_in(1'b1, 32'h4, 1'b0, 1'b0); tick();
    chk("str_pc1", pc_d, 32'h4); chk("str_cnt1", 32'(count_d), 32'd1);
    set_in(1'b1, 32'h8, 1'b0, 1'b0); tick();
    chk("str_pc2", pc_d, 32'h8); chk("str_cnt2", 32'(count_d), 32'd1);
    chk("str_pc4", pc4_d, 32'hC);
    set_in(1'b0, 32'h0, 1'b0, 1'b0); tick();
    chk("str_empty", 32'(valid_d), 32'd0);

    // Fill under stall; fifth entry refused
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0); tick();
      if (i == 3) begin
        chk("fill_cnt4", 32'(count_d), 32'd4);
        chk("fill_pcen0", 32'(pcen), 32'd0);
      end
    end
    chk("fill_cnt_after5", 32'(count_d), 32'd4);
    set_in(1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("drain_pc0", pc_d, 32'h100);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("drain_pc", pc_d, 32'h100 + 32'(i * 4));
    end
    tick();
    chk("drain_empty", 32'(count_d), 32'd0);

    // Full queue with simultaneous pop and push across pointer wrap
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h300 + 32'(i * 4), 1'b1, 1'b0); tick();
    end
    set_in(1'b1, 32'h310, 1'b0, 1'b0); #1;
    chk("full_pcen", 32'(pcen), 32'd1);
    tick();
    chk("full_cnt", 32'(count_d), 32'd4); chk("full_pc", pc_d, 32'h304);
    set_in(1'b1, 32'h314, 1'b0, 1'b0); tick();
    chk("full_pc2", pc_d, 32'h308);
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (6) tick();

    // Flush drops queued entries and the concurrent fetch
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h500 + 32'(i * 4), 1'b1, 1'b0); tick();
    end
    chk("fl_cnt3", 32'(count_d), 32'd3);
    set_in(1'b1, 32'h200, 1'b0, 1'b1); tick();
    chk("fl_cnt0", 32'(count_d), 32'd0); chk("fl_valid0", 32'(valid_d), 32'd0);
    set_in(1'b1, 32'h40, 1'b0, 1'b0); tick();
    chk("fl_next_pc", pc_d, 32'h40);
    set_in(1'b0, 32'h0, 1'b0, 1'b0); tick();

    // Flush while stalled on a full queue
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h600 + 32'(i * 4), 1'b1, 1'b0); tick();
    end
    set_in(1'b0, 32'h0, 1'b1, 1'b1); tick();
    chk("fls_cnt", 32'(count_d), 32'd0); chk("fls_pcen", 32'(pcen), 32'd1);
    set_in(1'b0, 32'h0, 1'b0, 1'b0); tick();

    // Asynchronous reset mid-stream with three entries held
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h700 + 32'(i * 4), 1'b1, 1'b0); tick();
    end
    chk("ar_cnt3", 32'(count_d), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_cnt", 32'(count_d), 32'd0);
    chk("ar_valid", 32'(valid_d), 32'd0);
    chk("ar_instr", instr_d, 32'h0000_0013);
    chk("ar_pcen", 32'(pcen), 32'd1);
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    set_in(1'b1, 32'h800, 1'b0, 1'b0); tick();
    chk("post_rst_pc", pc_d, 32'h800);
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
